dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu_if.sv | 30 +++
 rtl/dmem_lsu.sv | 109 ++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The master modport is the core plus memory side; the slave modport is the LSU.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_lsu.sv
// Single-request load/store unit: byte/halfword/word access to a 32-bit word memory,
// sub-word stores done as read-modify-write, misaligned/illegal requests answered with an error.
module dmem_lsu #(
  parameter int unsigned ADDR_W = 13
) (
  input logic         clk,
  input logic         rst,
  dmem_lsu_if.slave   bus
);
  localparam int unsigned AW = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, next_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;

  logic        accept_c;
  logic        err_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  assign accept_c = bus.req_valid && (state == IDLE);
  assign err_c    = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c) next_state = err_c ? RESP : ACCESS;
      ACCESS:  next_state = (r_we && (r_size != 2'b10)) ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lane select, load extension and sub-word merge
  always_comb begin
    byte_c  = bus.mem_rdata[{r_off, 3'b000} +: 8];
    half_c  = bus.mem_rdata[{r_off[1], 4'b0000} +: 16];
    load_c  = bus.mem_rdata;
    merge_c = bus.mem_rdata;
    case (r_size)
      2'b00: begin
        load_c = r_uns ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
        merge_c[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        load_c = r_uns ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
        merge_c[{r_off[1], 4'b0000} +: 16] = r_wdata;
      end
      default: ;
    endcase
  end

  // Request capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_uns         <= 1'b0;
      r_off         <= 2'b00;
      r_wdata       <= 16'h0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.req_ready <= (next_state == IDLE);
      bus.rsp_valid <= (next_state == RESP);
      // Word stores write in ACCESS; sub-word stores only after the read in ACCESS
      bus.mem_we    <= (next_state == WRITE) ||
                       (accept_c && !err_c && bus.req_we && (bus.req_size == 2'b10));
      if (accept_c) begin
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_off   <= bus.req_addr[1:0];
        r_wdata <= bus.req_wdata[15:0];
        if (!err_c) begin
          bus.mem_addr <= bus.req_addr[AW-1:2];
          if (bus.req_we && (bus.req_size == 2'b10)) bus.mem_wdata <= bus.req_wdata;
        end
      end
      if ((state == ACCESS) && (next_state == WRITE)) bus.mem_wdata <= merge_c;
      if ((next_state == RESP) && (state != RESP)) begin
        bus.rsp_err   <= (state == IDLE);
        bus.rsp_rdata <= ((state == ACCESS) && !r_we) ? load_c : 32'h0;
      end
    end
  end
endmodule
